pe_config_ctrl: RTL and testbench

- Runtime-configurable sequencer for the X-by-Y systolic PE array. It generates the following from a start/done handshake:
  - write enables for the west and north input FIFOs;
  - skewed read enables that feed the PEs;
  - the compute window and completion pulses;
  - back-pressured, row-sequential output FIFO reads.
- Inner dimension n is set per job, from 1 to N_MAX; array dimensions X and Y are fixed at elaboration.
- Sits between the EKF matrix-op scheduler and the PE array with its in/out FIFOs.

---
 rtl/pe_config_ctrl_pkg.sv | 30 +++
 rtl/pe_config_ctrl_skew.sv | 28 ++
 rtl/pe_config_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_pe_config_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_config_ctrl_pkg.sv
// Shared types and helpers for the PE array configuration sequencer.
package pe_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CAL   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

  // Default array geometry and the widths derived from it.
  localparam int PE_X     = 3;
  localparam int PE_Y     = 3;
  localparam int PE_N_MAX = 8;

  localparam int PE_NW  = clog2(PE_N_MAX + 1);
  localparam int PE_XCW = clog2(PE_X * PE_N_MAX + 1);
  localparam int PE_YCW = clog2(PE_Y * PE_N_MAX + 1);
  localparam int PE_TW  = clog2(PE_N_MAX + PE_X + PE_Y + 1);
  localparam int PE_OCW = clog2(PE_X * PE_Y + 1);

endpackage

// File: rtl/pe_config_ctrl_skew.sv
// Skewed read-enable window generator driven by the CAL timer.
// Bit k (0-based) is high for t in [k, k+n-1], so lane k starts one
// cycle after lane k-1 and stays open for exactly n cycles.
module skew_window_gen
  import pe_cfg_pkg::*;
#(
  parameter int K  = 3,
  parameter int NW = 4,
  parameter int TW = 4
) (
  input  logic          en_i,
  input  logic [TW-1:0] t_i,
  input  logic [NW-1:0] n_i,
  output logic [K-1:0]  win_o
);

  // One extra bit keeps k+n from overflowing the compare.
  logic [TW:0] t_ext;
  logic [TW:0] n_ext;

  assign t_ext = {1'b0, t_i};
  assign n_ext = (TW+1)'(n_i);

  for (genvar k = 0; k < K; k++) begin : g_win
    assign win_o[k] = en_i && (t_ext >= (TW+1)'(k)) && (t_ext < ((TW+1)'(k) + n_ext));
  end

endmodule

// File: rtl/pe_config_ctrl.sv
// Job sequencer for the X-by-Y systolic PE array: loads the west/north
// input FIFOs, runs the skewed compute window, then drains the output
// FIFOs row by row under downstream back-pressure.
//
// state | meaning
// IDLE  | waiting for start; validates n_len
// LOAD  | steering Xin/Yin words into west/north FIFOs
// CAL   | skewed FIFO reads and PE accumulate window
// DRAIN | row-sequential output FIFO reads gated by out_rdy
module pe_config_ctrl
  import pe_cfg_pkg::*;
#(
  parameter int X     = PE_X,
  parameter int Y     = PE_Y,
  parameter int N_MAX = PE_N_MAX
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  input  logic                       start,
  input  logic [clog2(N_MAX+1)-1:0]  n_len,
  input  logic                       Xin_val,
  input  logic                       Yin_val,
  input  logic                       out_rdy,
  output logic [X-1:0]               westin_wr_en,
  output logic [Y-1:0]               northin_wr_en,
  output logic [X-1:0]               westin_rd_en,
  output logic [Y-1:0]               northin_rd_en,
  output logic                       cal_en,
  output logic                       cal_done,
  output logic [X-1:0]               out_rd_en,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int NW  = clog2(N_MAX + 1);
  localparam int XCW = clog2(X * N_MAX + 1);
  localparam int YCW = clog2(Y * N_MAX + 1);
  localparam int TW  = clog2(N_MAX + X + Y + 1);
  localparam int OCW = clog2(X * Y + 1);
  localparam int OYW = clog2(Y + 1);

  state_e         state_q, state_d;
  logic [NW-1:0]  n_q, n_d;
  logic           err_q, err_d;
  logic [XCW-1:0] xcnt_q, xcnt_d;
  logic [NW-1:0]  xsub_q, xsub_d;
  logic [X-1:0]   row_q, row_d;
  logic [YCW-1:0] ycnt_q, ycnt_d;
  logic [Y-1:0]   col_q, col_d;
  logic [TW-1:0]  t_q, t_d;
  logic [OCW-1:0] ocnt_q, ocnt_d;
  logic [OYW-1:0] ocol_q, ocol_d;
  logic [X-1:0]   orow_q, orow_d;

  logic [XCW-1:0] x_total;
  logic [YCW-1:0] y_total;
  logic [TW-1:0]  t_last;
  logic           n_ok;
  logic           x_acc;
  logic           y_acc;
  logic           in_cal;

  assign x_total = XCW'(n_q) * XCW'(X);
  assign y_total = YCW'(n_q) * YCW'(Y);
  assign t_last  = TW'(n_q) + TW'(X + Y - 1);
  assign n_ok    = (n_len != '0) && (n_len <= NW'(N_MAX));
  // Words past the per-stream total are never accepted.
  assign x_acc   = (state_q == LOAD) && Xin_val && (xcnt_q != x_total);
  assign y_acc   = (state_q == LOAD) && Yin_val && (ycnt_q != y_total);
  assign in_cal  = (state_q == CAL);
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

  skew_window_gen #(.K(X), .NW(NW), .TW(TW)) u_west_skew (
    .en_i  (in_cal),
    .t_i   (t_q),
    .n_i   (n_q),
    .win_o (westin_rd_en)
  );

  skew_window_gen #(.K(Y), .NW(NW), .TW(TW)) u_north_skew (
    .en_i  (in_cal),
    .t_i   (t_q),
    .n_i   (n_q),
    .win_o (northin_rd_en)
  );

  // State and counter registers; reset clears everything and aborts a job.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      err_q   <= 1'b0;
      xcnt_q  <= '0;
      xsub_q  <= '0;
      row_q   <= '0;
      ycnt_q  <= '0;
      col_q   <= '0;
      t_q     <= '0;
      ocnt_q  <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      err_q   <= err_d;
      xcnt_q  <= xcnt_d;
      xsub_q  <= xsub_d;
      row_q   <= row_d;
      ycnt_q  <= ycnt_d;
      col_q   <= col_d;
      t_q     <= t_d;
      ocnt_q  <= ocnt_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    err_d         = err_q;
    xcnt_d        = xcnt_q;
    xsub_d        = xsub_q;
    row_d         = row_q;
    ycnt_d        = ycnt_q;
    col_d         = col_q;
    t_d           = t_q;
    ocnt_d        = ocnt_q;
    ocol_d        = ocol_q;
    orow_d        = orow_q;
    westin_wr_en  = '0;
    northin_wr_en = '0;
    cal_en        = 1'b0;
    cal_done      = 1'b0;
    out_rd_en     = '0;
    done          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (n_ok) begin
            n_d     = n_len;
            err_d   = 1'b0;
            xcnt_d  = '0;
            xsub_d  = '0;
            row_d   = X'(1);
            ycnt_d  = '0;
            col_d   = Y'(1);
            t_d     = '0;
            ocnt_d  = '0;
            ocol_d  = '0;
            orow_d  = X'(1);
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (x_acc) begin
          westin_wr_en = row_q;
          xcnt_d       = xcnt_q + XCW'(1);
          if (xsub_q == n_q - NW'(1)) begin
            xsub_d = '0;
            row_d  = row_q << 1;
          end else begin
            xsub_d = xsub_q + NW'(1);
          end
        end else if (Xin_val) begin
          err_d = 1'b1;
        end

        if (y_acc) begin
          northin_wr_en = col_q;
          ycnt_d        = ycnt_q + YCW'(1);
          col_d         = (col_q << 1) | (col_q >> (Y - 1));
        end else if (Yin_val) begin
          err_d = 1'b1;
        end

        // Enter CAL right after the final word of the later stream.
        if ((xcnt_d == x_total) && (ycnt_d == y_total)) begin
          state_d = CAL;
          t_d     = '0;
        end
      end

      CAL: begin
        cal_en = (t_q != '0) && (t_q < t_last);
        if (t_q == t_last) begin
          cal_done = 1'b1;
          state_d  = DRAIN;
        end else begin
          t_d = t_q + TW'(1);
        end
      end

      DRAIN: begin
        if (out_rdy) begin
          out_rd_en = orow_q;
          ocnt_d    = ocnt_q + OCW'(1);
          if (ocol_q == OYW'(Y - 1)) begin
            ocol_d = '0;
            orow_d = orow_q << 1;
          end else begin
            ocol_d = ocol_q + OYW'(1);
          end
          if (ocnt_q == OCW'(X * Y - 1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_config_ctrl.sv
module tb_pe_config_ctrl;

  localparam int X     = 3;
  localparam int Y     = 3;
  localparam int N_MAX = 8;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       start;
  logic [3:0] n_len;
  logic       Xin_val;
  logic       Yin_val;
  logic       out_rdy;
  logic [2:0] westin_wr_en;
  logic [2:0] northin_wr_en;
  logic [2:0] westin_rd_en;
  logic [2:0] northin_rd_en;
  logic       cal_en;
  logic       cal_done;
  logic [2:0] out_rd_en;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  pe_config_ctrl #(.X(X), .Y(Y), .N_MAX(N_MAX)) dut (
    .clk           (clk),
    .sys_rst       (sys_rst),
    .start         (start),
    .n_len         (n_len),
    .Xin_val       (Xin_val),
    .Yin_val       (Yin_val),
    .out_rdy       (out_rdy),
    .westin_wr_en  (westin_wr_en),
    .northin_wr_en (northin_wr_en),
    .westin_rd_en  (westin_rd_en),
    .northin_rd_en (northin_rd_en),
    .cal_en        (cal_en),
    .cal_done      (cal_done),
    .out_rd_en     (out_rd_en),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  logic [19:0] obs;
  assign obs = {westin_wr_en, northin_wr_en, westin_rd_en, northin_rd_en,
                cal_en, cal_done, out_rd_en, busy, done, err};

  int          checks   = 0;
  int          failures = 0;
  logic [19:0] sb_q[$];
  logic [19:0] exp_v;
  logic        exp_err;

  function automatic logic [19:0] mk(input logic [2:0] ww, input logic [2:0] nw,
                                     input logic [2:0] wr, input logic [2:0] nr,
                                     input logic ce, input logic cd, input logic [2:0] ord,
                                     input logic b, input logic d, input logic e);
    return {ww, nw, wr, nr, ce, cd, ord, b, d, e};
  endfunction

  // Lane b opens at t=b and stays open for n cycles.
  function automatic logic [2:0] win(input int t, input int n);
    logic [2:0] w;
    for (int b = 0; b < 3; b++) w[b] = (t >= b) && (t <= b + n - 1);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if (obs !== 20'h0) begin
      failures++;
      $display("FAIL async_reset got=%05h exp=%05h", obs, 20'h0);
    end
    exp_err = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic do_start(input int n);
    step();
    start = 1'b1; n_len = n[3:0]; Xin_val = 1'b0; Yin_val = 1'b0; out_rdy = 1'b0;
    sb_q.push_back(mk(3'b0, 3'b0, 3'b0, 3'b0, 1'b0, 1'b0, 3'b0, 1'b0, 1'b0, exp_err));
    @(negedge clk);
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL start n=%0d got=%05h exp=%05h", n, obs, exp_v);
    end
    exp_err = !((n >= 1) && (n <= N_MAX));
  endtask

  task automatic do_idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step();
      start = 1'b0; Xin_val = 1'b1; Yin_val = 1'b1; out_rdy = 1'b1;
      sb_q.push_back(mk(3'b0, 3'b0, 3'b0, 3'b0, 1'b0, 1'b0, 3'b0, 1'b0, 1'b0, exp_err));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL idle cyc=%0d got=%05h exp=%05h", c, obs, exp_v);
      end
    end
  endtask

  // order: 0 = X then Y, 1 = simultaneous, 2 = Y then X
  task automatic do_load(input int n, input int order, input int extra_x);
    bit xs[$];
    bit ys[$];
    int nx, ny, xk, yk;
    logic [2:0] ww, nw;
    nx = X * n + extra_x;
    ny = Y * n;
    xk = 0;
    yk = 0;
    if (order == 0) begin
      for (int i = 0; i < nx; i++) begin xs.push_back(1'b1); ys.push_back(1'b0); end
      for (int i = 0; i < ny; i++) begin xs.push_back(1'b0); ys.push_back(1'b1); end
    end else if (order == 1) begin
      for (int i = 0; i < ((nx > ny) ? nx : ny); i++) begin
        xs.push_back(i < nx); ys.push_back(i < ny);
      end
    end else begin
      for (int i = 0; i < ny; i++) begin xs.push_back(1'b0); ys.push_back(1'b1); end
      for (int i = 0; i < nx; i++) begin xs.push_back(1'b1); ys.push_back(1'b0); end
    end
    for (int c = 0; c < xs.size(); c++) begin
      step();
      start = 1'b0; out_rdy = 1'b0; Xin_val = xs[c]; Yin_val = ys[c];
      ww = (xs[c] && (xk < X * n)) ? (3'b001 << (xk / n)) : 3'b000;
      nw = (ys[c] && (yk < Y * n)) ? (3'b001 << (yk % Y)) : 3'b000;
      sb_q.push_back(mk(ww, nw, 3'b0, 3'b0, 1'b0, 1'b0, 3'b0, 1'b1, 1'b0, exp_err));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL load n=%0d order=%0d cyc=%0d got=%05h exp=%05h", n, order, c, obs, exp_v);
      end
      if (xs[c] && (xk >= X * n)) exp_err = 1'b1;
      if (ys[c] && (yk >= Y * n)) exp_err = 1'b1;
      if (xs[c]) xk++;
      if (ys[c]) yk++;
    end
  endtask

  task automatic do_cal(input int n, input int limit);
    int ce_cnt, last;
    ce_cnt = 0;
    last = n + X + Y - 1;
    for (int t = 0; (t <= last) && (t < limit); t++) begin
      step();
      start = 1'b0; Xin_val = 1'b0; Yin_val = 1'b0; out_rdy = 1'b0;
      sb_q.push_back(mk(3'b0, 3'b0, win(t, n), win(t, n),
                        (t >= 1) && (t <= n + X + Y - 2), (t == last),
                        3'b0, 1'b1, 1'b0, exp_err));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL cal n=%0d t=%0d got=%05h exp=%05h", n, t, obs, exp_v);
      end
      if (cal_en === 1'b1) ce_cnt++;
    end
    if (limit > last) begin
      checks++;
      if (ce_cnt != n + X + Y - 2) begin
        failures++;
        $display("FAIL cal_en_width n=%0d got=%0d exp=%0d", n, ce_cnt, n + X + Y - 2);
      end
    end
  endtask

  // mode 0: out_rdy held high; mode 1: out_rdy toggles 1,0,1,0...
  task automatic do_drain(input int mode, input bit poke_start);
    int reads, grants;
    bit fin;
    logic [2:0] ord;
    logic d;
    reads = 0;
    grants = 0;
    fin = 1'b0;
    for (int c = 0; (c < 40) && !fin; c++) begin
      step();
      Xin_val = 1'b0; Yin_val = 1'b0;
      out_rdy = (mode == 0) ? 1'b1 : (c % 2 == 0);
      start = poke_start && (c == 0);
      n_len = 4'd2;
      ord = out_rdy ? (3'b001 << (reads / Y)) : 3'b000;
      d = out_rdy && (reads == X * Y - 1);
      sb_q.push_back(mk(3'b0, 3'b0, 3'b0, 3'b0, 1'b0, 1'b0, ord, 1'b1, d, exp_err));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL drain mode=%0d cyc=%0d got=%05h exp=%05h", mode, c, obs, exp_v);
      end
      grants += $countones(out_rd_en);
      if (out_rdy) reads++;
      if (d) fin = 1'b1;
    end
    checks++;
    if (grants != X * Y) begin
      failures++;
      $display("FAIL drain_grants got=%0d exp=%0d", grants, X * Y);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b0; n_len = 4'd0;
    Xin_val = 1'b0; Yin_val = 1'b0; out_rdy = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 20'h0) begin
      failures++;
      $display("FAIL reset got=%05h exp=%05h", obs, 20'h0);
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_basic();
    do_start(3);
    do_load(3, 0, 0);
    do_cal(3, 100);
    do_drain(0, 1'b0);
    do_idle(2);
  endtask

  task automatic test_n_range();
    do_start(1);
    do_load(1, 0, 0);
    do_cal(1, 100);
    do_drain(0, 1'b0);
    do_idle(1);
    do_start(N_MAX);
    do_load(N_MAX, 0, 0);
    do_cal(N_MAX, 100);
    do_drain(0, 1'b0);
    do_idle(1);
  endtask

  task automatic test_interleave();
    do_start(3);
    do_load(3, 1, 0);
    do_cal(3, 100);
    do_drain(0, 1'b0);
    do_idle(1);
    do_start(3);
    do_load(3, 2, 0);
    do_cal(3, 100);
    do_drain(0, 1'b0);
    do_idle(1);
  endtask

  task automatic test_backpressure();
    do_start(2);
    do_load(2, 1, 0);
    do_cal(2, 100);
    do_drain(1, 1'b0);
    do_idle(2);
  endtask

  task automatic test_errors();
    do_start(0);
    do_idle(2);
    pulse_reset();
    do_start(9);
    do_idle(2);
    do_start(3);
    do_load(3, 0, 1);
    do_cal(3, 100);
    do_drain(0, 1'b0);
    do_idle(2);
    do_start(1);
    do_load(1, 1, 0);
    do_cal(1, 100);
    do_drain(0, 1'b0);
    do_idle(1);
  endtask

  task automatic test_back_to_back();
    do_start(3);
    do_load(3, 0, 0);
    do_cal(3, 3);
    pulse_reset();
    do_start(2);
    do_load(2, 0, 0);
    do_cal(2, 100);
    do_drain(0, 1'b1);
    do_idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_n_range();
    test_interleave();
    test_backpressure();
    test_errors();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
